// File: rtl/nota_to_tono_if.sv
// Note-index-in / square-wave-out bundle between the note mapper and the tone generator.
interface nota_to_tono_if;
    logic [7:0] nota_final;
    logic       tono;
    logic       activo;
    logic       busy;
    logic [7:0] nota_actual;

    modport master (output nota_final, input tono, activo, busy, nota_actual);
    modport slave  (input nota_final, output tono, activo, busy, nota_actual);
endinterface

// File: rtl/nota_to_tono.sv
// Note index -> 50% duty square tone: octave/key decode, table lookup, half-period counter.
// A change lands k+2 cycles after it is sampled (k = octave); no backpressure, input is level-sampled.
module nota_to_tono #(
    parameter longint unsigned CLK_FREQ_HZ = 100_000_000,
    parameter int unsigned     CNT_W       = 19
) (
    input  logic           clk,
    input  logic           rst_n,
    nota_to_tono_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RUN, DECODE, LOAD} state_t;

    // Half-periods for C3..C4 at 100 MHz, rescaled (rounded) to the actual clock.
    function automatic logic [CNT_W-1:0] scale(input longint unsigned base);
        return CNT_W'((base * CLK_FREQ_HZ + 64'd50_000_000) / 64'd100_000_000);
    endfunction

    localparam logic [CNT_W-1:0] H_TAB [16] = '{
        scale(64'd382225), scale(64'd360776), scale(64'd340524), scale(64'd321412),
        scale(64'd303372), scale(64'd286345), scale(64'd270275), scale(64'd255105),
        scale(64'd240787), scale(64'd227273), scale(64'd214517), scale(64'd202477),
        scale(64'd191113), '0, '0, '0
    };

    state_t           state_q, state_d;
    logic [7:0]       nota_reg_q, nota_reg_d;
    logic [7:0]       rem_q, rem_d;
    logic [2:0]       oct_q, oct_d;
    logic [CNT_W-1:0] half_q, half_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tono_q, tono_d;
    logic             activo_q, activo_d;
    logic [7:0]       nota_actual_q, nota_actual_d;

    logic       chg;
    logic       valid_note;
    logic [3:0] key_idx;

    assign chg        = (bus.nota_final != nota_reg_q);
    assign valid_note = (nota_reg_q != 8'd0) && (nota_reg_q <= 8'd65);
    assign key_idx    = 4'(rem_q - 8'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, RUN: if (chg) state_d = DECODE;
            DECODE: begin
                if (chg)                              state_d = DECODE;
                else if (!valid_note || rem_q <= 8'd13) state_d = LOAD;
            end
            LOAD:    state_d = valid_note ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        nota_reg_d    = nota_reg_q;
        rem_d         = rem_q;
        oct_d         = oct_q;
        half_d        = half_q;
        cnt_d         = cnt_q;
        tono_d        = tono_q;
        activo_d      = activo_q;
        nota_actual_d = nota_actual_q;

        // The old tone keeps running while a new note is being decoded.
        if (activo_q) begin
            if (cnt_q == half_q - CNT_W'(1)) begin
                cnt_d  = '0;
                tono_d = ~tono_q;
            end else begin
                cnt_d  = cnt_q + CNT_W'(1);
            end
        end

        if (state_q != LOAD && chg) begin
            nota_reg_d = bus.nota_final;
            rem_d      = bus.nota_final;
            oct_d      = '0;
        end else if (state_q == DECODE && valid_note && rem_q > 8'd13) begin
            rem_d = rem_q - 8'd13;
            oct_d = oct_q + 3'd1;
        end else if (state_q == LOAD) begin
            cnt_d = '0;
            if (valid_note) begin
                half_d        = H_TAB[key_idx] >> oct_q;
                tono_d        = 1'b1;
                activo_d      = 1'b1;
                nota_actual_d = nota_reg_q;
            end else begin
                tono_d        = 1'b0;
                activo_d      = 1'b0;
                nota_actual_d = 8'd0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nota_reg_q    <= '0;
            rem_q         <= '0;
            oct_q         <= '0;
            half_q        <= '0;
            cnt_q         <= '0;
            tono_q        <= 1'b0;
            activo_q      <= 1'b0;
            nota_actual_q <= '0;
        end else begin
            nota_reg_q    <= nota_reg_d;
            rem_q         <= rem_d;
            oct_q         <= oct_d;
            half_q        <= half_d;
            cnt_q         <= cnt_d;
            tono_q        <= tono_d;
            activo_q      <= activo_d;
            nota_actual_q <= nota_actual_d;
        end
    end

    always_comb begin
        bus.tono        = tono_q;
        bus.activo      = activo_q;
        bus.busy        = (state_q == DECODE) || (state_q == LOAD);
        bus.nota_actual = nota_actual_q;
    end
endmodule
